sync_fifo_reader: RTL and testbench



---
 rtl/sync_fifo_reader.sv | 95 +++++++++
 tb/tb_sync_fifo_reader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_reader.sv
// rtl/sync_fifo_reader.sv - read-side master for sync_fifo: absorbs read latency, emits a valid/ready stream
// with burst-boundary marking and a delivered-word counter.
module sync_fifo_reader #(
    parameter int DATA_WIDTH  = 16,
    parameter int BURST_LEN   = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   fifo_empty,
    input  logic [DATA_WIDTH-1:0]  fifo_data_out,
    output logic                   fifo_rd_en,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_last,
    output logic [COUNT_WIDTH-1:0] word_count,
    output logic                   busy
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] buf0;
    logic [DATA_WIDTH-1:0] buf1;
    logic [1:0]            occ;
    logic                  inflight;
    logic [BW-1:0]         beat;
    logic                  pop;
    logic                  cap;
    logic [1:0]            occ_post;

    assign m_valid  = (occ != 2'd0);
    assign m_data   = buf0;
    assign m_last   = m_valid && (beat == LAST_BEAT);
    assign busy     = (state != IDLE);
    assign pop      = m_valid && m_ready;
    assign cap      = inflight;
    assign occ_post = occ - {1'b0, pop};

    // Count the word already requested so the two-entry buffer can never overflow.
    assign fifo_rd_en = (state == ACTIVE) && !fifo_empty
                        && (({1'b0, occ_post} + {2'b00, inflight}) < 3'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            buf0       <= '0;
            buf1       <= '0;
            occ        <= 2'd0;
            inflight   <= 1'b0;
            beat       <= '0;
            word_count <= '0;
        end else begin
            inflight <= fifo_rd_en;
            case ({pop, cap})
                2'b11: begin
                    if (occ == 2'd2) begin
                        buf0 <= buf1;
                        buf1 <= fifo_data_out;
                    end else begin
                        buf0 <= fifo_data_out;
                    end
                end
                2'b10: buf0 <= buf1;
                2'b01: begin
                    if (occ == 2'd0) buf0 <= fifo_data_out;
                    else             buf1 <= fifo_data_out;
                end
                default: ;
            endcase
            occ <= occ_post + {1'b0, cap};

            if (pop) begin
                word_count <= word_count + COUNT_WIDTH'(1);
                beat       <= (beat == LAST_BEAT) ? '0 : beat + BW'(1);
            end

            case (state)
                IDLE:    if (enable && !fifo_empty) state <= ACTIVE;
                ACTIVE:  if (!enable) state <= DRAIN;
                DRAIN: begin
                    if (enable)                             state <= ACTIVE;
                    else if (!inflight && occ == 2'd0)      state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fifo_reader.sv
// tb/tb_sync_fifo_reader.sv - self-checking bench for sync_fifo_reader with a behavioural FIFO model
module tb_sync_fifo_reader;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        fifo_empty;
    logic [15:0] fifo_data_out;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        m_last;
    logic [15:0] word_count;
    logic        busy;

    sync_fifo_reader #(.DATA_WIDTH(16), .BURST_LEN(4), .COUNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data_out(fifo_data_out), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .word_count(word_count),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: registered read, data valid the cycle after fifo_rd_en
    logic [15:0] mem [0:1023];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        flush = 1'b0;
    int          rd_empty_err = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_data_out <= mem[rd_ptr[9:0]];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    always @(negedge clk) if (fifo_rd_en && fifo_empty) rd_empty_err = rd_empty_err + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] v);
        mem[wr_ptr[9:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; m_ready = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic        en;
        logic        rdy;
        logic        rd;
        logic        v;
        logic [15:0] d;
        logic        l;
        logic [15:0] wc;
        logic        b;
    } vec_t;

    vec_t vt [0:20];

    task automatic set_row(input int i, input logic en, input logic rdy, input logic rd, input logic v,
                           input logic [15:0] d, input logic l, input logic [15:0] wc, input logic b);
        vt[i].en = en; vt[i].rdy = rdy; vt[i].rd = rd; vt[i].v = v;
        vt[i].d = d; vt[i].l = l; vt[i].wc = wc; vt[i].b = b;
    endtask

    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            enable = vt[i].en; m_ready = vt[i].rdy;
            @(negedge clk);
            check("rd_en", i, 32'(fifo_rd_en), 32'(vt[i].rd));
            check("m_valid", i, 32'(m_valid), 32'(vt[i].v));
            if (vt[i].v) check("m_data", i, 32'(m_data), 32'(vt[i].d));
            check("m_last", i, 32'(m_last), 32'(vt[i].l));
            check("word_count", i, 32'(word_count), 32'(vt[i].wc));
            check("busy", i, 32'(busy), 32'(vt[i].b));
            @(posedge clk); #1;
        end
    endtask

    logic [15:0] got_d [0:255];
    logic        got_l [0:255];
    int          got_c [0:255];
    int          got_n;
    int          stab_bad;
    int          rd_seen;

    task automatic run_collect(input int n, input int maxc, input bit rand_rdy);
        int   cyc = 0;
        logic prev_stall = 1'b0;
        logic [15:0] pd = '0;
        logic pl = 1'b0;
        got_n = 0; stab_bad = 0; rd_seen = 0;
        while (got_n < n && cyc < maxc) begin
            m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (prev_stall && !(m_valid && m_data == pd && m_last == pl)) stab_bad = stab_bad + 1;
            prev_stall = m_valid && !m_ready; pd = m_data; pl = m_last;
            if (fifo_rd_en) rd_seen = rd_seen + 1;
            if (m_valid && m_ready) begin
                got_d[got_n] = m_data; got_l[got_n] = m_last; got_c[got_n] = cyc;
                got_n = got_n + 1;
            end
            @(posedge clk); #1;
            cyc = cyc + 1;
        end
        check("collect_count", n, 32'(got_n), 32'(n));
    endtask

    logic [15:0] e3 [0:199];

    initial begin
        int bad, nrd, nv, nb, snap;
        reset = 1'b1; enable = 1'b0; m_ready = 1'b0;

        // test 1 rows 0..11 ; test 4 rows 12..20
        set_row(0,  1,1, 0,0,16'h0000,0,16'd0,0);
        set_row(1,  1,1, 1,0,16'h0000,0,16'd0,1);
        set_row(2,  1,1, 1,0,16'h0000,0,16'd0,1);
        set_row(3,  1,1, 1,1,16'h0001,0,16'd0,1);
        set_row(4,  1,1, 1,1,16'h0002,0,16'd1,1);
        set_row(5,  1,1, 1,1,16'h0003,0,16'd2,1);
        set_row(6,  1,1, 1,1,16'h0004,1,16'd3,1);
        set_row(7,  1,1, 1,1,16'h0005,0,16'd4,1);
        set_row(8,  1,1, 1,1,16'h0006,0,16'd5,1);
        set_row(9,  1,1, 0,1,16'h0007,0,16'd6,1);
        set_row(10, 1,1, 0,1,16'h0008,1,16'd7,1);
        set_row(11, 1,1, 0,0,16'h0000,0,16'd8,1);
        set_row(12, 1,0, 0,0,16'h0000,0,16'd0,0);
        set_row(13, 1,0, 1,0,16'h0000,0,16'd0,1);
        set_row(14, 1,0, 1,0,16'h0000,0,16'd0,1);
        set_row(15, 0,0, 0,1,16'h0041,0,16'd0,1);
        set_row(16, 0,1, 0,1,16'h0041,0,16'd0,1);
        set_row(17, 0,1, 0,1,16'h0042,0,16'd1,1);
        set_row(18, 0,1, 0,0,16'h0000,0,16'd2,1);
        set_row(19, 0,1, 0,0,16'h0000,0,16'd2,0);
        set_row(20, 0,1, 0,0,16'h0000,0,16'd2,0);

        // test 1: eight-word burst at full rate
        do_reset();
        for (int i = 1; i <= 8; i++) push(16'(i));
        apply_rows(0, 11);

        // test 2: backpressure with six words queued
        do_reset();
        for (int i = 0; i < 6; i++) push(16'h0011 + 16'(i));
        enable = 1'b1; m_ready = 1'b0;
        nrd = 0; bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (fifo_rd_en) nrd = nrd + 1;
            if (c >= 3 && !(m_valid && m_data == 16'h0011 && !m_last)) bad = bad + 1;
            @(posedge clk); #1;
        end
        check("t2_stall_rd_pulses", 0, 32'(nrd), 32'd2);
        check("t2_stall_hold", 0, 32'(bad), 32'd0);
        run_collect(6, 40, 1'b0);
        bad = 0;
        for (int i = 0; i < got_n; i++) begin
            check("t2_data", i, 32'(got_d[i]), 32'(16'h0011 + 16'(i)));
            if (got_c[i] != got_c[0] + i) bad = bad + 1;
        end
        check("t2_gaps", 0, 32'(bad), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t2_no_extra", 0, 32'(m_valid), 32'd0);
        check("t2_word_count", 0, 32'(word_count), 32'd6);

        // test 3: random backpressure over 200 words
        do_reset();
        for (int i = 0; i < 200; i++) begin
            e3[i] = 16'($urandom);
            push(e3[i]);
        end
        enable = 1'b1;
        run_collect(200, 3000, 1'b1);
        bad = 0; nb = 0;
        for (int i = 0; i < got_n; i++) begin
            if (got_d[i] != e3[i]) bad = bad + 1;
            if (got_l[i] != (i % 4 == 3)) nb = nb + 1;
        end
        check("t3_sequence", 0, 32'(bad), 32'd0);
        check("t3_last", 0, 32'(nb), 32'd0);
        check("t3_stable", 0, 32'(stab_bad), 32'd0);
        check("t3_word_count", 0, 32'(word_count), 32'd200);

        // test 4: enable dropped with words buffered and one in flight
        do_reset();
        for (int i = 0; i < 10; i++) push(16'h0041 + 16'(i));
        apply_rows(12, 20);
        check("t4_fifo_left", 0, 32'(wr_ptr - rd_ptr), 32'd8);

        // test 5: FIFO runs dry while ACTIVE, then a single late word
        do_reset();
        for (int i = 0; i < 3; i++) push(16'h0051 + 16'(i));
        enable = 1'b1;
        run_collect(3, 30, 1'b0);
        nrd = 0; nv = 0; nb = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (fifo_rd_en) nrd = nrd + 1;
            if (m_valid) nv = nv + 1;
            if (!busy) nb = nb + 1;
            @(posedge clk); #1;
        end
        check("t5_no_rd", 0, 32'(nrd), 32'd0);
        check("t5_no_valid", 0, 32'(nv), 32'd0);
        check("t5_busy", 0, 32'(nb), 32'd0);
        push(16'hBEEF);
        run_collect(1, 20, 1'b0);
        check("t5_data", 0, 32'(got_d[0]), 32'h0000BEEF);
        check("t5_last", 0, 32'(got_l[0]), 32'd1);
        check("t5_word_count", 0, 32'(word_count), 32'd4);

        // test 6: asynchronous reset while a beat is presented
        do_reset();
        for (int i = 0; i < 8; i++) push(16'h0061 + 16'(i));
        enable = 1'b1;
        run_collect(2, 30, 1'b0);
        m_ready = 1'b0;
        nv = 0;
        for (int c = 0; c < 10 && nv == 0; c++) begin
            @(negedge clk);
            if (m_valid) nv = 1;
            else begin @(posedge clk); #1; end
        end
        check("t6_valid_before_reset", 0, 32'(nv), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_rd_en", 0, 32'(fifo_rd_en), 32'd0);
        check("t6_rst_valid", 0, 32'(m_valid), 32'd0);
        check("t6_rst_data", 0, 32'(m_data), 32'd0);
        check("t6_rst_last", 0, 32'(m_last), 32'd0);
        check("t6_rst_word_count", 0, 32'(word_count), 32'd0);
        check("t6_rst_busy", 0, 32'(busy), 32'd0);
        enable = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        snap = rd_ptr;
        enable = 1'b1;
        run_collect(4, 40, 1'b0);
        check("t6_first_after_reset", 0, 32'(got_d[0]), 32'(mem[snap[9:0]]));
        for (int i = 0; i < 4; i++) check("t6_last", i, 32'(got_l[i]), 32'(i == 3));
        check("t6_word_count", 0, 32'(word_count), 32'd4);

        check("rd_while_empty", 0, 32'(rd_empty_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
